bus_arbiter: RTL and testbench

- Responder side of the Z80 BUSRQ/BUSAK protocol. Sits between the TV80 core and up to two bus-mastering peripherals, for example simpledma and a second DMA channel.
- Collects the masters' active-low bus requests and forwards a single request to the CPU.
- On CPU acknowledge, grants exactly one master using round-robin order and muxes that master's address, data and strobes onto the shared system bus.
- Releases the bus back to the CPU when the master drops its request.

---
 rtl/bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master BUSRQ/BUSAK responder in front of a TV80 core.
// Forwards one request to the CPU, grants round-robin and muxes the owner onto the shared bus.
module bus_arbiter #(
   parameter logic [15:0] MAX_HOLD = 16'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        cpu_busrq_n,
   input  logic        cpu_busak_n,
   input  logic        m0_busrq_n,
   output logic        m0_busak_n,
   input  logic [15:0] m0_addr,
   input  logic [7:0]  m0_data,
   input  logic        m0_iorq_n,
   input  logic        m0_mreq_n,
   input  logic        m0_rd_n,
   input  logic        m0_wr_n,
   input  logic        m1_busrq_n,
   output logic        m1_busak_n,
   input  logic [15:0] m1_addr,
   input  logic [7:0]  m1_data,
   input  logic        m1_iorq_n,
   input  logic        m1_mreq_n,
   input  logic        m1_rd_n,
   input  logic        m1_wr_n,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data,
   output logic        bus_iorq_n,
   output logic        bus_mreq_n,
   output logic        bus_rd_n,
   output logic        bus_wr_n,
   output logic        bus_en,
   output logic [1:0]  owner,
   output logic        hold_err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_GRANT    = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic        last_q, last_d;
   logic        cpu_busrq_n_q, cpu_busrq_n_d;
   logic        m0_busak_n_q, m0_busak_n_d;
   logic        m1_busak_n_q, m1_busak_n_d;
   logic        bus_en_q, bus_en_d;
   logic [1:0]  owner_q, owner_d;
   logic        hold_err_q, hold_err_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;

   logic        req0_s, req1_s, sel_req_s;
   logic [15:0] hold_inc_s;

   assign req0_s     = ~m0_busrq_n;
   assign req1_s     = ~m1_busrq_n;
   assign sel_req_s  = sel_q ? req1_s : req0_s;
   assign hold_inc_s = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : (hold_cnt_q + 16'd1);

   // State register and all registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         sel_q         <= 1'b0;
         last_q        <= 1'b1;
         cpu_busrq_n_q <= 1'b1;
         m0_busak_n_q  <= 1'b1;
         m1_busak_n_q  <= 1'b1;
         bus_en_q      <= 1'b0;
         owner_q       <= 2'b00;
         hold_err_q    <= 1'b0;
         hold_cnt_q    <= 16'd0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         last_q        <= last_d;
         cpu_busrq_n_q <= cpu_busrq_n_d;
         m0_busak_n_q  <= m0_busak_n_d;
         m1_busak_n_q  <= m1_busak_n_d;
         bus_en_q      <= bus_en_d;
         owner_q       <= owner_d;
         hold_err_q    <= hold_err_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   // Next-state and next-output logic of the handshake FSM
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_d        = last_q;
      cpu_busrq_n_d = cpu_busrq_n_q;
      m0_busak_n_d  = m0_busak_n_q;
      m1_busak_n_d  = m1_busak_n_q;
      bus_en_d      = bus_en_q;
      owner_d       = owner_q;
      hold_err_d    = hold_err_q;
      hold_cnt_d    = hold_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (req0_s || req1_s) begin
               state_d       = S_WAIT_ACK;
               cpu_busrq_n_d = 1'b0;
               // On a tie the master that did not own the bus last time wins
               if (req0_s && req1_s) begin
                  sel_d = ~last_q;
               end else begin
                  sel_d = req1_s;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_ACK: begin
            if (!sel_req_s) begin
               state_d       = S_RELEASE;
               cpu_busrq_n_d = 1'b1;
               last_d        = sel_q;
            end else if (!cpu_busak_n) begin
               state_d      = S_GRANT;
               m0_busak_n_d = sel_q;
               m1_busak_n_d = ~sel_q;
               bus_en_d     = 1'b1;
               owner_d      = sel_q ? 2'b10 : 2'b01;
               hold_cnt_d   = 16'd0;
            end else begin
               state_d = S_WAIT_ACK;
            end
         end
         S_GRANT: begin
            if (cpu_busak_n || !sel_req_s) begin
               state_d       = S_RELEASE;
               cpu_busrq_n_d = 1'b1;
               m0_busak_n_d  = 1'b1;
               m1_busak_n_d  = 1'b1;
               bus_en_d      = 1'b0;
               owner_d       = 2'b00;
               last_d        = sel_q;
               // CPU withdrawing its acknowledge under a live grant is a protocol fault
               if (cpu_busak_n) begin
                  hold_err_d = 1'b1;
               end else begin
                  hold_err_d = hold_err_q;
               end
            end else begin
               hold_cnt_d = hold_inc_s;
               if ((MAX_HOLD != 16'd0) && (hold_inc_s == MAX_HOLD)) begin
                  hold_err_d = 1'b1;
               end else begin
                  hold_err_d = hold_err_q;
               end
            end
         end
         S_RELEASE: begin
            if (cpu_busak_n) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RELEASE;
            end
         end
         default: begin
            state_d       = S_IDLE;
            cpu_busrq_n_d = 1'b1;
            m0_busak_n_d  = 1'b1;
            m1_busak_n_d  = 1'b1;
            bus_en_d      = 1'b0;
            owner_d       = 2'b00;
         end
      endcase
   end

   // Shared-bus mux; parked at idle values whenever no master owns the bus
   always_comb begin
      bus_addr   = 16'h0000;
      bus_data   = 8'h00;
      bus_iorq_n = 1'b1;
      bus_mreq_n = 1'b1;
      bus_rd_n   = 1'b1;
      bus_wr_n   = 1'b1;
      if (!bus_en_q) begin
         bus_addr = 16'h0000;
      end else if (sel_q) begin
         bus_addr   = m1_addr;
         bus_data   = m1_data;
         bus_iorq_n = m1_iorq_n;
         bus_mreq_n = m1_mreq_n;
         bus_rd_n   = m1_rd_n;
         bus_wr_n   = m1_wr_n;
      end else begin
         bus_addr   = m0_addr;
         bus_data   = m0_data;
         bus_iorq_n = m0_iorq_n;
         bus_mreq_n = m0_mreq_n;
         bus_rd_n   = m0_rd_n;
         bus_wr_n   = m0_wr_n;
      end
   end

   assign cpu_busrq_n = cpu_busrq_n_q;
   assign m0_busak_n  = m0_busak_n_q;
   assign m1_busak_n  = m1_busak_n_q;
   assign bus_en      = bus_en_q;
   assign owner       = owner_q;
   assign hold_err    = hold_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard queue of expected values, immediate-assert checks.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_busrq_n, cpu_busak_n;
   logic        m0_busrq_n, m0_busak_n, m1_busrq_n, m1_busak_n;
   logic [15:0] m0_addr, m1_addr, bus_addr;
   logic [7:0]  m0_data, m1_data, bus_data;
   logic        m0_iorq_n, m0_mreq_n, m0_rd_n, m0_wr_n;
   logic        m1_iorq_n, m1_mreq_n, m1_rd_n, m1_wr_n;
   logic        bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n;
   logic        bus_en, hold_err;
   logic [1:0]  owner;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(16'd8)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
      .m0_busrq_n(m0_busrq_n), .m0_busak_n(m0_busak_n), .m0_addr(m0_addr), .m0_data(m0_data),
      .m0_iorq_n(m0_iorq_n), .m0_mreq_n(m0_mreq_n), .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n),
      .m1_busrq_n(m1_busrq_n), .m1_busak_n(m1_busak_n), .m1_addr(m1_addr), .m1_data(m1_data),
      .m1_iorq_n(m1_iorq_n), .m1_mreq_n(m1_mreq_n), .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n),
      .bus_addr(bus_addr), .bus_data(bus_data),
      .bus_iorq_n(bus_iorq_n), .bus_mreq_n(bus_mreq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
      .bus_en(bus_en), .owner(owner), .hold_err(hold_err)
   );

   function automatic logic [31:0] mk(input logic [1:0] own, input logic en, input logic ak1,
                                      input logic ak0, input logic rq, input logic he);
      return {25'd0, own, en, ak1, ak0, rq, he};
   endfunction

   function automatic logic [31:0] stat();
      return {25'd0, owner, bus_en, m1_busak_n, m0_busak_n, cpu_busrq_n, hold_err};
   endfunction

   function automatic logic [31:0] strobes();
      return {28'd0, bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic cmp(input logic [31:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL sb_empty: observed %0h required an expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      cpu_busak_n = 1'b1;
      m0_busrq_n  = 1'b1;
      m1_busrq_n  = 1'b1;
      #12;
      reset_n = 1'b1;
      tick();
   endtask

   // Request -> CPU ack -> grant -> hold -> release -> CPU handover, with checks at each step
   task automatic serve(input logic [1:0] req, input int win, input int hold);
      logic [1:0] own;
      own = (win == 1) ? 2'b10 : 2'b01;
      m0_busrq_n = ~req[0];
      m1_busrq_n = ~req[1];
      expect_v("wait_ack", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      tick(); cmp(stat());
      cpu_busak_n = 1'b0;
      expect_v("grant", mk(own, 1'b1, (win == 1) ? 1'b0 : 1'b1, (win == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0));
      expect_v("grant_addr", (win == 1) ? {16'd0, m1_addr} : {16'd0, m0_addr});
      expect_v("grant_data", (win == 1) ? {24'd0, m1_data} : {24'd0, m0_data});
      expect_v("grant_strb", (win == 1) ? 32'h5 : 32'hA);
      tick(); cmp(stat()); cmp({16'd0, bus_addr}); cmp({24'd0, bus_data}); cmp(strobes());
      for (int i = 0; i < hold; i++) begin
         expect_v("hold", mk(own, 1'b1, (win == 1) ? 1'b0 : 1'b1, (win == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0));
         tick(); cmp(stat());
      end
      if (win == 1) m1_busrq_n = 1'b1;
      else          m0_busrq_n = 1'b1;
      expect_v("release", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      expect_v("rel_addr", 32'h0);
      expect_v("rel_strb", 32'hF);
      tick(); cmp(stat()); cmp({16'd0, bus_addr}); cmp(strobes());
      expect_v("rel_hold", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tick(); cmp(stat());
      cpu_busak_n = 1'b1;
      expect_v("to_idle", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tick(); cmp(stat());
   endtask

   initial begin
      m0_addr = 16'h8010; m0_data = 8'hA5;
      m0_iorq_n = 1'b1; m0_mreq_n = 1'b0; m0_rd_n = 1'b1; m0_wr_n = 1'b0;
      m1_addr = 16'h1234; m1_data = 8'h3C;
      m1_iorq_n = 1'b0; m1_mreq_n = 1'b1; m1_rd_n = 1'b0; m1_wr_n = 1'b1;

      do_reset();
      expect_v("reset_stat", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      expect_v("reset_addr", 32'h0);
      expect_v("reset_strb", 32'hF);
      cmp(stat()); cmp({16'd0, bus_addr}); cmp(strobes());

      // Single request, then simultaneous pair (m0 first), then round-robin alternation
      serve(2'b01, 0, 3);
      do_reset();
      serve(2'b11, 0, 3);
      serve(2'b10, 1, 3);
      serve(2'b11, 0, 2);
      serve(2'b11, 1, 2);
      serve(2'b01, 0, 2);

      // Abort before acknowledge; late ack in IDLE is ignored
      m0_busrq_n = 1'b0;
      expect_v("abort_wait", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      tick(); cmp(stat());
      m0_busrq_n = 1'b1;
      expect_v("abort_rel", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tick(); cmp(stat());
      expect_v("abort_idle", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tick(); cmp(stat());
      cpu_busak_n = 1'b0;
      expect_v("idle_ack_ignored", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tick(); cmp(stat());
      cpu_busak_n = 1'b1;
      tick();

      // Hold limit of 8 GRANT cycles: flag raised, grant kept, flag sticky
      do_reset();
      m0_busrq_n = 1'b0;
      tick();
      cpu_busak_n = 1'b0;
      tick();
      for (int k = 1; k <= 12; k++) begin
         expect_v("hold_lim", mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, (k >= 8) ? 1'b1 : 1'b0));
         tick(); cmp(stat());
      end
      m0_busrq_n = 1'b1;
      expect_v("hold_rel", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      tick(); cmp(stat());
      cpu_busak_n = 1'b1;
      expect_v("hold_sticky", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      tick(); tick(); cmp(stat());
      #2 reset_n = 1'b0;
      #1;
      expect_v("hold_clr", 32'h0);
      cmp({31'd0, hold_err});
      tick(); reset_n = 1'b1; tick();

      // CPU drops acknowledge mid-GRANT
      m0_busrq_n = 1'b0;
      tick();
      cpu_busak_n = 1'b0;
      tick(); tick();
      cpu_busak_n = 1'b1;
      expect_v("ack_drop", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
      tick(); cmp(stat());
      m0_busrq_n = 1'b1;
      tick(); tick();

      // Asynchronous reset in the middle of an m1 grant
      do_reset();
      m1_busrq_n = 1'b0;
      tick();
      cpu_busak_n = 1'b0;
      tick();
      expect_v("m1_granted", mk(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      cmp(stat());
      #2 reset_n = 1'b0;
      #1;
      expect_v("arst_stat", mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      expect_v("arst_strb", 32'hF);
      expect_v("arst_addr", 32'h0);
      cmp(stat()); cmp(strobes()); cmp({16'd0, bus_addr});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
